// File: rtl/team_06_audio_link_rx_pkg.sv
// Shared types and constants for the walkie-talkie audio link receiver.
package team_06_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_bit_state_t;

   typedef enum logic {
      HUNT,
      LOCKED
   } link_state_t;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/team_06_audio_link_rx_if.sv
// Serial-line input and speaker-side outputs of the audio link receiver.
interface team_06_audio_link_rx_if;

   logic       en;
   logic       rx_in;
   logic [7:0] spk_aud;
   logic       spk_valid;
   logic       rx_active;
   logic       parity_err;
   logic       frame_err;

   // Environment / control side: owns the line and the enable.
   modport master (
      output en, rx_in,
      input  spk_aud, spk_valid, rx_active, parity_err, frame_err
   );

   // Receiver side.
   modport slave (
      input  en, rx_in,
      output spk_aud, spk_valid, rx_active, parity_err, frame_err
   );

endinterface

// File: rtl/team_06_audio_link_rx_uart_rx_byte.sv
// Serial byte receiver: input synchronizer, bit-centre divider and frame FSM.
// Emits one registered pulse per completed frame together with its parity/stop status.
module team_06_uart_rx_byte
   import team_06_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       en_i,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_done_o,
   output logic       par_bad_o,
   output logic       stop_bad_o
);

   localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic             sync1_q, sync2_q, rx_prev_q;
   logic             fall;
   rx_bit_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       data_q, data_d;
   logic             par_q, par_d;
   logic             done_q, done_d;
   logic             par_bad_q, par_bad_d;
   logic             stop_bad_q, stop_bad_d;

   // The edge-detect history stays live while disabled, so re-enabling on a
   // line that is already low does not look like a fresh start bit.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= rx_i;
         sync2_q   <= sync1_q;
         rx_prev_q <= sync2_q;
      end
   end

   assign fall = rx_prev_q & ~sync2_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         data_q     <= '0;
         par_q      <= 1'b0;
         done_q     <= 1'b0;
         par_bad_q  <= 1'b0;
         stop_bad_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         data_q     <= data_d;
         par_q      <= par_d;
         done_q     <= done_d;
         par_bad_q  <= par_bad_d;
         stop_bad_q <= stop_bad_d;
      end
   end

   // NOTE: every always_comb output gets a default first, which rules out inferred latches.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_W'(1);
      bit_d      = bit_q;
      data_d     = data_q;
      par_d      = par_q;
      done_d     = 1'b0;
      par_bad_d  = 1'b0;
      stop_bad_d = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (fall) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = sync2_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d  = '0;
               data_d = {sync2_q, data_q[7:1]};
               bit_d  = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = PARITY;
            end
         end
         PARITY: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               par_d   = sync2_q;
               state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d      = '0;
               done_d     = 1'b1;
               par_bad_d  = ^{data_q, par_q};
               stop_bad_d = ~sync2_q;
               state_d    = sync2_q ? IDLE : BREAK;
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (sync2_q) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      if (!en_i) begin
         state_d    = IDLE;
         cnt_d      = '0;
         bit_d      = '0;
         data_d     = '0;
         par_d      = 1'b0;
         done_d     = 1'b0;
         par_bad_d  = 1'b0;
         stop_bad_d = 1'b0;
      end
   end

   assign byte_o      = data_q;
   assign byte_done_o = done_q;
   assign par_bad_o   = par_bad_q;
   assign stop_bad_o  = stop_bad_q;

endmodule

// File: rtl/team_06_audio_link_rx.sv
// Audio link receiver top: sync-byte lock, carrier timeout and speaker output registers.
module team_06_audio_link_rx
   import team_06_pkg::*;
#(
   parameter int         CLKS_PER_BIT    = 16,
   parameter logic [7:0] SYNC_BYTE       = DEFAULT_SYNC_BYTE,
   parameter int         CARRIER_TIMEOUT = 2000
) (
   input logic                    clk,
   input logic                    nrst,
   team_06_audio_link_rx_if.slave link
);

   localparam int               TMO_W    = $clog2(CARRIER_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CARRIER_TIMEOUT - 1);

   logic [7:0]       rx_byte;
   logic             rx_done, rx_par_bad, rx_stop_bad;
   logic             good_byte;
   link_state_t      link_q, link_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [7:0]       aud_q, aud_d;
   logic             valid_q, valid_d;
   logic             perr_q, perr_d;
   logic             ferr_q, ferr_d;

   team_06_uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx_byte (
      .clk         (clk),
      .nrst        (nrst),
      .en_i        (link.en),
      .rx_i        (link.rx_in),
      .byte_o      (rx_byte),
      .byte_done_o (rx_done),
      .par_bad_o   (rx_par_bad),
      .stop_bad_o  (rx_stop_bad)
   );

   assign good_byte = rx_done & ~rx_par_bad & ~rx_stop_bad;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         link_q  <= HUNT;
         tmo_q   <= '0;
         aud_q   <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         link_q  <= link_d;
         tmo_q   <= tmo_d;
         aud_q   <= aud_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   // A good byte landing on the timeout cycle is checked first, so it keeps the lock.
   always_comb begin
      link_d  = link_q;
      tmo_d   = tmo_q;
      aud_d   = aud_q;
      valid_d = 1'b0;
      ferr_d  = rx_done & rx_stop_bad;
      perr_d  = rx_done & rx_par_bad & ~rx_stop_bad;

      case (link_q)
         HUNT: begin
            tmo_d = '0;
            if (good_byte && (rx_byte == SYNC_BYTE)) link_d = LOCKED;
         end
         LOCKED: begin
            if (good_byte) begin
               aud_d   = rx_byte;
               valid_d = 1'b1;
               tmo_d   = '0;
            end else if (ferr_d || (tmo_q == TMO_LAST)) begin
               link_d = HUNT;
               aud_d  = '0;
               tmo_d  = '0;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
      endcase

      if (!link.en) begin
         link_d  = HUNT;
         tmo_d   = '0;
         aud_d   = '0;
         valid_d = 1'b0;
         perr_d  = 1'b0;
         ferr_d  = 1'b0;
      end
   end

   assign link.spk_aud    = aud_q;
   assign link.spk_valid  = valid_q;
   assign link.rx_active  = (link_q == LOCKED);
   assign link.parity_err = perr_q;
   assign link.frame_err  = ferr_q;

endmodule

// File: tb/tb_team_06_audio_link_rx.sv
// Directed bench for the audio link receiver: frame table plus timeout/abort sequences.
module tb_team_06_audio_link_rx;

   localparam int CPB = 4;
   localparam int TMO = 100;
   localparam int GAP = 4;
   // Counter ticks from driving the start bit to the output pulse:
   // 2 sync + 1 edge detect + 2 half bit + 40 bit times (8 data, parity, stop) + 1 output register.
   localparam int LAT = 46;
   localparam int NV  = 11;

   typedef struct packed {
      logic [7:0] data;
      logic       par;
      logic       stp;
      logic [1:0] exp_valid;
      logic [1:0] exp_perr;
      logic [1:0] exp_ferr;
      logic [7:0] exp_aud;
      logic       exp_active;
   } vec_t;

   logic clk = 1'b0;
   logic nrst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   int   n_valid = 0, n_perr = 0, n_ferr = 0, n_fall = 0;
   int   valid_cyc = 0, rise_cyc = 0, fall_cyc = 0;
   logic act_prev = 1'b0;
   int   b_valid, b_perr, b_ferr, b_fall;
   int   start_cyc;
   int   vcap;
   logic was_active;
   vec_t vecs [NV];

   team_06_audio_link_rx_if u_if ();

   team_06_audio_link_rx #(
      .CLKS_PER_BIT    (CPB),
      .SYNC_BYTE       (8'hA5),
      .CARRIER_TIMEOUT (TMO)
   ) u_dut (
      .clk  (clk),
      .nrst (nrst),
      .link (u_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (u_if.spk_valid === 1'b1) begin
         n_valid   <= n_valid + 1;
         valid_cyc <= cyc;
      end
      if (u_if.parity_err === 1'b1) n_perr <= n_perr + 1;
      if (u_if.frame_err === 1'b1) n_ferr <= n_ferr + 1;
      if ((u_if.rx_active === 1'b1) && !act_prev) rise_cyc <= cyc;
      if ((u_if.rx_active !== 1'b1) && act_prev) begin
         fall_cyc <= cyc;
         n_fall   <= n_fall + 1;
      end
      act_prev <= (u_if.rx_active === 1'b1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) tick(1);
   endtask

   task automatic snap();
      b_valid = n_valid;
      b_perr  = n_perr;
      b_ferr  = n_ferr;
      b_fall  = n_fall;
   endtask

   task automatic drive_bit(input logic b);
      u_if.rx_in = b;
      tick(CPB);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
      start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(par);
      drive_bit(stp);
      u_if.rx_in = 1'b1;
      tick(GAP);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_valid"}, n_valid - b_valid, 0);
      check({tag, "_perr"},  n_perr  - b_perr,  0);
      check({tag, "_ferr"},  n_ferr  - b_ferr,  0);
      check({tag, "_active"}, u_if.rx_active, 0);
      check({tag, "_aud"},   u_if.spk_aud,    0);
   endtask

   task automatic good_pair(input string tag, input logic [7:0] d);
      send_frame(8'hA5, 1'b0, 1'b1);
      snap();
      send_frame(d, ^d, 1'b1);
      check({tag, "_valid"}, n_valid - b_valid, 1);
      check({tag, "_aud"}, u_if.spk_aud, d);
      check({tag, "_active"}, u_if.rx_active, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //                data   par  stp  valid perr ferr aud    active
      vecs[0]  = '{8'hA5, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1}; // lock, no sample
      vecs[1]  = '{8'h3C, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 8'h3C, 1'b1};
      vecs[2]  = '{8'h41, 1'b1, 1'b1, 2'd0, 2'd1, 2'd0, 8'h3C, 1'b1}; // bad parity, held
      vecs[3]  = '{8'h10, 1'b1, 1'b0, 2'd0, 2'd0, 2'd1, 8'h00, 1'b0}; // bad stop, unlock
      vecs[4]  = '{8'h22, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0}; // ignored in HUNT
      vecs[5]  = '{8'hA5, 1'b1, 1'b1, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0}; // corrupt sync
      vecs[6]  = '{8'hA5, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1};
      vecs[7]  = '{8'h5A, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 8'h5A, 1'b1};
      vecs[8]  = '{8'hA5, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 8'hA5, 1'b1}; // sync value as audio
      vecs[9]  = '{8'h01, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 8'h00, 1'b0}; // both bad: frame only
      vecs[10] = '{8'h7E, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0};

      nrst       = 1'b0;
      u_if.en    = 1'b1;
      u_if.rx_in = 1'b1;
      tick(5);
      check("rst_active", u_if.rx_active, 0);
      check("rst_aud", u_if.spk_aud, 0);
      check("rst_valid", u_if.spk_valid, 0);
      check("rst_perr", u_if.parity_err, 0);
      check("rst_ferr", u_if.frame_err, 0);

      nrst = 1'b1;
      snap();
      tick(200);
      check_quiet("idle");

      for (int i = 0; i < NV; i++) begin
         snap();
         was_active = u_if.rx_active;
         send_frame(vecs[i].data, vecs[i].par, vecs[i].stp);
         check($sformatf("v%0d_valid", i), n_valid - b_valid, 32'(vecs[i].exp_valid));
         check($sformatf("v%0d_perr", i), n_perr - b_perr, 32'(vecs[i].exp_perr));
         check($sformatf("v%0d_ferr", i), n_ferr - b_ferr, 32'(vecs[i].exp_ferr));
         check($sformatf("v%0d_aud", i), u_if.spk_aud, 32'(vecs[i].exp_aud));
         check($sformatf("v%0d_active", i), u_if.rx_active, 32'(vecs[i].exp_active));
         if (vecs[i].exp_valid != 2'd0)
            check($sformatf("v%0d_valid_lat", i), valid_cyc - start_cyc, LAT);
         if (vecs[i].exp_active && !was_active)
            check($sformatf("v%0d_lock_lat", i), rise_cyc - start_cyc, LAT);
      end

      // Carrier timeout after the last sample.
      good_pair("tmo_pre", 8'h55);
      vcap = valid_cyc;
      snap();
      wait_cyc(vcap + TMO + 10);
      check("tmo_fall_dist", fall_cyc - vcap, TMO);
      check("tmo_falls", n_fall - b_fall, 1);
      check("tmo_active", u_if.rx_active, 0);
      check("tmo_aud", u_if.spk_aud, 0);

      // A byte completing on the timeout cycle keeps the lock.
      good_pair("tie_pre", 8'h55);
      vcap = valid_cyc;
      snap();
      wait_cyc(vcap + TMO - LAT);
      send_frame(8'h66, 1'b0, 1'b1);
      tick(3);
      check("tie_valid_dist", valid_cyc - vcap, TMO);
      check("tie_aud", u_if.spk_aud, 8'h66);
      check("tie_active", u_if.rx_active, 1);
      check("tie_falls", n_fall - b_fall, 0);

      // One-clock glitch: false start, then a normal byte still lands.
      snap();
      u_if.rx_in = 1'b0;
      tick(1);
      u_if.rx_in = 1'b1;
      tick(20);
      check("glitch_valid", n_valid - b_valid, 0);
      check("glitch_perr", n_perr - b_perr, 0);
      check("glitch_ferr", n_ferr - b_ferr, 0);
      check("glitch_active", u_if.rx_active, 1);
      snap();
      send_frame(8'h5A, 1'b0, 1'b1);
      check("post_glitch_valid", n_valid - b_valid, 1);
      check("post_glitch_aud", u_if.spk_aud, 8'h5A);

      // Disable mid-byte, re-enable while the line is still low.
      snap();
      u_if.rx_in = 1'b0;
      tick(10);
      u_if.en = 1'b0;
      tick(1);
      check("en_low_active", u_if.rx_active, 0);
      check("en_low_aud", u_if.spk_aud, 0);
      tick(3);
      u_if.en = 1'b1;
      tick(6);
      u_if.rx_in = 1'b1;
      tick(60);
      check_quiet("en_drop");
      good_pair("en_rec", 8'h81);

      // Asynchronous reset mid-byte.
      snap();
      u_if.rx_in = 1'b0;
      tick(12);
      #2;
      nrst = 1'b0;
      #1;
      check("arst_active", u_if.rx_active, 0);
      check("arst_aud", u_if.spk_aud, 0);
      u_if.rx_in = 1'b1;
      tick(3);
      nrst = 1'b1;
      tick(60);
      check_quiet("arst");
      good_pair("arst_rec", 8'h42);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
